// File: rtl/fifo_block_drainer_pkg.sv
// Shared types and constant helpers for the block drainer.
// State encoding is fixed at 2 bits: IDLE=0, XFER=1, DONE=2.
// Width helpers are usable in parameter defaults.
package fifo_block_drainer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_block_drainer_idle_watchdog.sv
// Purpose: counts consecutive idle cycles and flags the last allowed one.
// Latency: expired is combinational from the registered timer and enable.
// Backpressure: none; clear wins over enable, TIMEOUT_CYC=0 disables it.
module idle_watchdog #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, enable};
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);
            logic [TO_W-1:0] timer;

            // Idle-cycle counter: restarts on any activity, advances while stalled.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    timer <= '0;
                end else if (clear) begin
                    timer <= '0;
                end else if (enable) begin
                    timer <= timer + 1'b1;
                end
            end

            // The stalled cycle that would complete the idle budget.
            assign expired = enable && (timer == LAST);
        end
    endgenerate

endmodule

// File: rtl/fifo_block_drainer.sv
// Purpose: moves BLOCK_LEN words from a show-ahead source FIFO to a destination FIFO.
// Latency: data passes through combinationally; done one cycle after the last word.
// Backpressure: src_empty or dst_full stalls that cycle only; idle watchdog aborts.
module fifo_block_drainer
    import fifo_block_drainer_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BLOCK_LEN   = 32,
    parameter int CNT_W       = clog2(BLOCK_LEN + 1),
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = max_int(1, clog2(TIMEOUT_CYC + 1)),
    parameter int CONTINUOUS  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              src_empty,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_rd,
    input  logic              dst_full,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    state_t state;
    logic   xfer;
    logic   wd_clear;
    logic   wd_enable;
    logic   wd_expired;

    // A word moves only when both FIFOs allow it; abort suppresses the pop.
    assign xfer     = (state == XFER) && !src_empty && !dst_full && !abort;
    assign src_rd   = xfer;
    assign dst_wr   = xfer;
    assign dst_data = src_data;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Timer runs only on stalled XFER cycles; any transfer or other state restarts it.
    assign wd_clear  = (state != XFER) || xfer;
    assign wd_enable = (state == XFER) && !xfer;

    idle_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Block sequencing, word counting and the registered timeout pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= XFER;
                        count <= '0;
                    end
                end
                XFER: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        count <= count + 1'b1;
                        if (count == LAST_CNT) state <= DONE;
                    end else if (wd_expired) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (CONTINUOUS != 0) begin
                        state <= XFER;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_block_drainer.sv
// Bench for fifo_block_drainer: one single-shot and one continuous instance.
// Source FIFOs are ring buffers in the bench; a per-cycle behavioural model
// predicts every output, plus directed timing checks from the block contract.
module tb_fifo_block_drainer;

    localparam int BL = 4;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start[2], abort[2], dst_full[2], hold_empty[2];
    logic       src_empty[2];
    logic [7:0] src_data[2];
    logic       src_rd[2], dst_wr[2], busy[2], done[2], timeout[2];
    logic [7:0] dst_data[2];
    logic [2:0] count[2];

    logic [7:0] smem[2][256];
    int         wp[2], rp[2];

    assign src_empty[0] = (wp[0] == rp[0]) || hold_empty[0];
    assign src_empty[1] = (wp[1] == rp[1]) || hold_empty[1];
    assign src_data[0]  = smem[0][rp[0] & 255];
    assign src_data[1]  = smem[1][rp[1] & 255];

    fifo_block_drainer #(.DATA_W(8), .BLOCK_LEN(BL), .TIMEOUT_CYC(TO), .CONTINUOUS(0)) dut (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .src_empty(src_empty[0]), .src_data(src_data[0]), .src_rd(src_rd[0]),
        .dst_full(dst_full[0]), .dst_data(dst_data[0]), .dst_wr(dst_wr[0]),
        .busy(busy[0]), .done(done[0]), .timeout(timeout[0]), .count(count[0]));

    fifo_block_drainer #(.DATA_W(8), .BLOCK_LEN(BL), .TIMEOUT_CYC(TO), .CONTINUOUS(1)) dut_c (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .src_empty(src_empty[1]), .src_data(src_data[1]), .src_rd(src_rd[1]),
        .dst_full(dst_full[1]), .dst_data(dst_data[1]), .dst_wr(dst_wr[1]),
        .busy(busy[1]), .done(done[1]), .timeout(timeout[1]), .count(count[1]));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: armed/bubble flags, words moved, idle cycles seen.
    bit m_act[2], m_bub[2], m_to[2];
    int m_cnt[2], m_idle[2];

    int         wcyc0[$];
    logic [7:0] wdat0[$];
    int         done0[$], done1[$], to0[$];

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_bub[i] = 0; m_to[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        smem[i][wp[i] & 255] = d;
        wp[i]++;
    endtask

    task automatic clear_logs();
        wcyc0.delete(); wdat0.delete(); done0.delete(); done1.delete(); to0.delete();
    endtask

    task automatic run_cycle();
        bit popped[2];
        bit ex;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ex = m_act[i] && !src_empty[i] && !dst_full[i] && !abort[i];
            check_eq($sformatf("busy%0d", i),    busy[i],    m_act[i] || m_bub[i]);
            check_eq($sformatf("done%0d", i),    done[i],    m_bub[i]);
            check_eq($sformatf("timeout%0d", i), timeout[i], m_to[i]);
            check_eq($sformatf("src_rd%0d", i),  src_rd[i],  ex);
            check_eq($sformatf("dst_wr%0d", i),  dst_wr[i],  ex);
            check_eq($sformatf("count%0d", i),   count[i],   m_cnt[i]);
            if (ex) check_eq($sformatf("data%0d", i), dst_data[i], smem[i][rp[i] & 255]);
            popped[i] = src_rd[i];
            m_to[i] = 0;
            if (!m_act[i] && !m_bub[i]) begin
                if (start[i]) begin m_act[i] = 1; m_cnt[i] = 0; m_idle[i] = 0; end
            end else if (abort[i]) begin
                m_act[i] = 0; m_bub[i] = 0;
            end else if (m_bub[i]) begin
                m_bub[i] = 0;
                if (i == 1) begin m_act[i] = 1; m_cnt[i] = 0; m_idle[i] = 0; end
            end else if (ex) begin
                m_cnt[i]++; m_idle[i] = 0;
                if (m_cnt[i] == BL) begin m_act[i] = 0; m_bub[i] = 1; end
            end else begin
                m_idle[i]++;
                if (m_idle[i] == TO) begin m_act[i] = 0; m_to[i] = 1; end
            end
        end
        if (dst_wr[0]) begin wcyc0.push_back(cyc); wdat0.push_back(dst_data[0]); end
        if (done[0]) done0.push_back(cyc);
        if (done[1]) done1.push_back(cyc);
        if (timeout[0]) to0.push_back(cyc);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (popped[i] && rp[i] != wp[i]) rp[i]++;
        cyc++;
    endtask

    int t0;
    logic [7:0] exp_d[4];

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; abort[i] = 0; dst_full[i] = 0; hold_empty[i] = 0;
            wp[i] = 0; rp[i] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy[0], 0);
        check_eq("rst_done", done[0], 0);
        check_eq("rst_timeout", timeout[0], 0);
        check_eq("rst_count", count[0], 0);
        check_eq("rst_src_rd", src_rd[0], 0);
        check_eq("rst_busy_c", busy[1], 0);
        reset = 1'b0;

        // Plain block: four words, no stalls.
        clear_logs();
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) push(0, exp_d[k]);
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin start[0] = (k == 0); run_cycle(); end
        check_eq("t1_nwr", wcyc0.size(), 4);
        for (int k = 0; k < 4; k++) if (k < wcyc0.size()) begin
            check_eq("t1_wcyc", wcyc0[k] - t0, k + 1);
            check_eq("t1_wdat", wdat0[k], exp_d[k]);
        end
        check_eq("t1_ndone", done0.size(), 1);
        if (done0.size() > 0) check_eq("t1_done_cyc", done0[0] - t0, 5);
        check_eq("t1_count", count[0], 4);

        // Destination full in cycles 2-3.
        clear_logs();
        exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int k = 0; k < 4; k++) push(0, exp_d[k]);
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            start[0] = (k == 0); dst_full[0] = (k == 2 || k == 3); run_cycle();
        end
        dst_full[0] = 0;
        check_eq("t2_nwr", wcyc0.size(), 4);
        for (int k = 0; k < 4; k++) if (k < wcyc0.size()) begin
            check_eq("t2_wcyc", wcyc0[k] - t0, (k == 0) ? 1 : k + 3);
            check_eq("t2_wdat", wdat0[k], exp_d[k]);
        end
        if (done0.size() > 0) check_eq("t2_done_cyc", done0[0] - t0, 7);
        else check_eq("t2_ndone", done0.size(), 1);

        // Starved source: timeout 11 cycles after the second word.
        clear_logs();
        push(0, 8'h5A); push(0, 8'h5B);
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin start[0] = (k == 0); run_cycle(); end
        check_eq("t3_nwr", wcyc0.size(), 2);
        check_eq("t3_nto", to0.size(), 1);
        if (to0.size() > 0) check_eq("t3_to_cyc", to0[0] - t0, 13);
        check_eq("t3_count", count[0], 2);
        check_eq("t3_busy", busy[0], 0);
        check_eq("t3_ndone", done0.size(), 0);

        // Continuous mode: three back-to-back blocks.
        clear_logs();
        for (int k = 0; k < 12; k++) push(1, 8'(8'h30 + k));
        t0 = cyc;
        for (int k = 0; k < 17; k++) begin
            start[1] = (k == 0); abort[1] = (k == 16); run_cycle();
        end
        abort[1] = 0;
        check_eq("t4_ndone", done1.size(), 3);
        for (int k = 0; k < 3; k++) if (k < done1.size())
            check_eq("t4_done_cyc", done1[k] - t0, 5 * (k + 1));
        check_eq("t4_busy", busy[1], 0);

        // Abort in the cycle of the third transfer.
        clear_logs();
        for (int k = 0; k < 4; k++) push(0, 8'(8'hC0 + k));
        for (int k = 0; k < 6; k++) begin
            start[0] = (k == 0); abort[0] = (k == 3); run_cycle();
        end
        abort[0] = 0;
        check_eq("t5_nwr", wcyc0.size(), 2);
        check_eq("t5_count", count[0], 2);
        check_eq("t5_ndone", done0.size(), 0);
        check_eq("t5_busy", busy[0], 0);
        rp[0] = wp[0];

        // Asynchronous reset mid-block, then a clean block.
        for (int k = 0; k < 4; k++) push(0, 8'(8'h61 + k));
        for (int k = 0; k < 3; k++) begin start[0] = (k == 0); run_cycle(); end
        check_eq("t6_pre_busy", busy[0], 1);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_rst_src_rd", src_rd[0], 0);
        check_eq("t6_rst_dst_wr", dst_wr[0], 0);
        check_eq("t6_rst_busy", busy[0], 0);
        check_eq("t6_rst_count", count[0], 0);
        reset = 1'b0;
        #1;
        model_reset();
        rp[0] = wp[0];
        clear_logs();
        for (int k = 0; k < 4; k++) push(0, 8'(8'h71 + k));
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin start[0] = (k == 0); run_cycle(); end
        check_eq("t6_nwr", wcyc0.size(), 4);
        if (done0.size() > 0) check_eq("t6_done_cyc", done0[0] - t0, 5);
        else check_eq("t6_ndone", done0.size(), 1);
        check_eq("t6_count", count[0], 4);

        // Randomized traffic in phases of plentiful and scarce source data.
        for (int ph = 0; ph < 4; ph++) begin
            int pp;
            pp = (ph % 2 == 0) ? 2 : 15;
            for (int k = 0; k < 700; k++) begin
                for (int i = 0; i < 2; i++) begin
                    start[i]      = ($urandom % 8) == 0;
                    abort[i]      = ($urandom % 64) == 0;
                    dst_full[i]   = ($urandom % 4) == 0;
                    hold_empty[i] = ($urandom % 5) == 0;
                    if (($urandom % pp) == 0 && (wp[i] - rp[i]) < 200) push(i, 8'($urandom));
                end
                run_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
